// File: rtl/memory_access.sv
// MEM stage: registers the EX/MEM payload, runs lw/lb/lbu/sw/sb on the data
// memory through a req/ack handshake and emits one writeback record per op.
//
// Parameters:
//   TIMEOUT     cycles to wait for dmem_ack before aborting (>= 2)
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ex_valid/ex_ready    handshake with Execute (transfer on both high)
//   ALUResult            ALU result / effective address
//   storeData            rt value for stores
//   MemRead, MemWrite    load / store (both high => load)
//   byteOp, signedLoad   byte access, sign-extend byte loads
//   RegWrite, WriteReg   register writeback control
//   dmem_*               data memory request/ack port
//   wb_*                 writeback record to WB (wb_valid is a pulse)
//   fault                pulse on misaligned word access or timeout
module memory_access #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ALUResult,
    input  logic [31:0] storeData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        byteOp,
    input  logic        signedLoad,
    input  logic        RegWrite,
    input  logic [4:0]  WriteReg,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic        wb_RegWrite,
    output logic [4:0]  wb_WriteReg,
    output logic [31:0] wb_data,
    output logic        fault
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    state_t r_state;
    state_t w_next;

    logic [CW-1:0] r_cnt;
    logic          r_load;
    logic          r_byte;
    logic          r_signed;
    logic [1:0]    r_lane;
    logic          r_regwrite;
    logic [4:0]    r_writereg;
    logic [31:0]   r_alu;

    logic        w_xfer;
    logic        w_mem;
    logic        w_misal;
    logic        w_start;
    logic        w_done;
    logic        w_tmo;
    logic [7:0]  w_rbyte;
    logic [31:0] w_ldata;

    assign ex_ready = (r_state == IDLE);
    assign w_xfer   = ex_valid && ex_ready;
    assign w_mem    = MemRead || MemWrite;
    assign w_misal  = w_mem && !byteOp && (ALUResult[1:0] != 2'b00);
    assign w_start  = w_xfer && w_mem && !w_misal;
    assign w_done   = (r_state == ACCESS) && dmem_ack;
    // Ack in the abort cycle wins, so the timeout only fires without ack.
    assign w_tmo    = (r_state == ACCESS) && !dmem_ack && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                if (w_done || w_tmo) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Select the addressed byte lane of the returned word.
    always_comb begin
        w_rbyte = dmem_rdata[7:0];
        unique case (r_lane)
            2'd0: w_rbyte = dmem_rdata[7:0];
            2'd1: w_rbyte = dmem_rdata[15:8];
            2'd2: w_rbyte = dmem_rdata[23:16];
            2'd3: w_rbyte = dmem_rdata[31:24];
            default: w_rbyte = dmem_rdata[7:0];
        endcase
    end

    always_comb begin
        w_ldata = dmem_rdata;
        if (r_byte) begin
            if (r_signed) begin
                w_ldata = {{24{w_rbyte[7]}}, w_rbyte};
            end else begin
                w_ldata = {24'd0, w_rbyte};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_load      <= 1'b0;
            r_byte      <= 1'b0;
            r_signed    <= 1'b0;
            r_lane      <= 2'd0;
            r_regwrite  <= 1'b0;
            r_writereg  <= 5'd0;
            r_alu       <= 32'd0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'd0;
            dmem_wdata  <= 32'd0;
            dmem_be     <= 4'd0;
            wb_valid    <= 1'b0;
            wb_RegWrite <= 1'b0;
            wb_WriteReg <= 5'd0;
            wb_data     <= 32'd0;
            fault       <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            fault    <= 1'b0;
            if (r_state == IDLE) begin
                if (w_xfer && !w_mem) begin
                    wb_valid    <= 1'b1;
                    wb_RegWrite <= RegWrite;
                    wb_WriteReg <= WriteReg;
                    wb_data     <= ALUResult;
                end else if (w_xfer && w_misal) begin
                    fault       <= 1'b1;
                    wb_valid    <= 1'b1;
                    wb_RegWrite <= 1'b0;
                    wb_WriteReg <= WriteReg;
                    wb_data     <= 32'd0;
                end else if (w_start) begin
                    r_cnt      <= '0;
                    r_load     <= MemRead;
                    r_byte     <= byteOp;
                    r_signed   <= signedLoad;
                    r_lane     <= ALUResult[1:0];
                    r_regwrite <= RegWrite;
                    r_writereg <= WriteReg;
                    r_alu      <= ALUResult;
                    dmem_req   <= 1'b1;
                    dmem_we    <= !MemRead;
                    dmem_addr  <= {ALUResult[31:2], 2'b00};
                    if (byteOp) begin
                        dmem_be <= 4'b0001 << ALUResult[1:0];
                    end else begin
                        dmem_be <= 4'hF;
                    end
                    if (MemRead) begin
                        dmem_wdata <= 32'd0;
                    end else if (byteOp) begin
                        dmem_wdata <= {4{storeData[7:0]}};
                    end else begin
                        dmem_wdata <= storeData;
                    end
                end
            end else begin
                if (w_done) begin
                    dmem_req    <= 1'b0;
                    wb_valid    <= 1'b1;
                    wb_RegWrite <= r_load && r_regwrite;
                    wb_WriteReg <= r_writereg;
                    wb_data     <= r_load ? w_ldata : r_alu;
                end else if (w_tmo) begin
                    dmem_req    <= 1'b0;
                    fault       <= 1'b1;
                    wb_valid    <= 1'b1;
                    wb_RegWrite <= 1'b0;
                    wb_WriteReg <= r_writereg;
                    wb_data     <= 32'd0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed cases then randomized ops checked
// against an arithmetic reference of the load/store lane rules.
module tb_memory_access;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic [31:0] ALUResult = '0;
    logic [31:0] storeData = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic        byteOp = 1'b0;
    logic        signedLoad = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  WriteReg = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic        wb_RegWrite;
    logic [4:0]  wb_WriteReg;
    logic [31:0] wb_data;
    logic        fault;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    memory_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ALUResult(ALUResult), .storeData(storeData),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .byteOp(byteOp), .signedLoad(signedLoad),
        .RegWrite(RegWrite), .WriteReg(WriteReg),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite),
        .wb_WriteReg(wb_WriteReg), .wb_data(wb_data),
        .fault(fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ld_ref(input bit bop, input bit sgn,
                                           input logic [31:0] alu,
                                           input logic [31:0] rd);
        int unsigned b;
        if (!bop) return rd;
        b = (rd >> (8 * (alu % 4))) & 32'd255;
        if (sgn && b >= 128) return 32'(int'(b) - 256);
        return 32'(b);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction end to end. lat = wait cycles after req before
    // ack; lat >= TO means memory never answers.
    task automatic do_op(input bit rd, input bit wr, input bit bop,
                         input bit sgn, input bit rw,
                         input logic [4:0] wreg,
                         input logic [31:0] alu, input logic [31:0] sd,
                         input int lat, input logic [31:0] rdata);
        bit is_mem;
        bit misal;
        bit acked;
        logic [3:0] be_exp;
        is_mem = rd || wr;
        misal = is_mem && !bop && (alu % 4 != 0);
        be_exp = bop ? 4'(1 << (alu % 4)) : 4'hF;
        ex_valid = 1'b1;
        MemRead = rd;
        MemWrite = wr;
        byteOp = bop;
        signedLoad = sgn;
        RegWrite = rw;
        WriteReg = wreg;
        ALUResult = alu;
        storeData = sd;
        chk("ready_at_issue", ex_ready, 1);
        step();
        ex_valid = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        ALUResult = $urandom;
        if (!is_mem) begin
            chk("alu_wb_valid", wb_valid, 1);
            chk("alu_wb_data", wb_data, alu);
            chk("alu_wb_rw", wb_RegWrite, rw);
            chk("alu_wb_reg", wb_WriteReg, wreg);
            chk("alu_fault", fault, 0);
            chk("alu_no_req", dmem_req, 0);
        end else if (misal) begin
            chk("mis_no_req", dmem_req, 0);
            chk("mis_fault", fault, 1);
            chk("mis_wb_valid", wb_valid, 1);
            chk("mis_wb_rw", wb_RegWrite, 0);
        end else begin
            chk("req_we", dmem_we, !rd);
            chk("req_be", dmem_be, be_exp);
            if (!rd)
                chk("req_wdata", dmem_wdata,
                    bop ? sd[7:0] * 32'h01010101 : sd);
            acked = 0;
            for (int k = 0; k < TO && !acked; k++) begin
                chk("req_held", dmem_req, 1);
                chk("req_addr", dmem_addr, alu & ~32'h3);
                chk("busy_not_ready", ex_ready, 0);
                chk("busy_no_wb", wb_valid, 0);
                if (k == lat) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rdata;
                    acked = 1;
                end
                step();
                dmem_ack = 1'b0;
                dmem_rdata = $urandom;
            end
            chk("done_req_low", dmem_req, 0);
            chk("done_ready", ex_ready, 1);
            chk("done_wb_valid", wb_valid, 1);
            if (acked) begin
                chk("done_fault", fault, 0);
                chk("done_wb_rw", wb_RegWrite, rd ? rw : 1'b0);
                chk("done_wb_reg", wb_WriteReg, wreg);
                if (rd) chk("load_data", wb_data, ld_ref(bop, sgn, alu, rdata));
            end else begin
                chk("tmo_fault", fault, 1);
                chk("tmo_wb_rw", wb_RegWrite, 0);
            end
        end
        step();
        chk("pulse_wb_low", wb_valid, 0);
        chk("pulse_fault_low", fault, 0);
    endtask

    initial begin
        logic [31:0] a;
        int kind;
        #2;
        chk("rst_ready", ex_ready, 1);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rw", wb_RegWrite, 0);
        chk("rst_wb_reg", wb_WriteReg, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_fault", fault, 0);
        step();
        rst_n = 1'b1;
        step();

        do_op(0, 0, 0, 0, 1, 5'd8, 32'h1234, 0, 0, 0);
        do_op(1, 0, 0, 0, 1, 5'd9, 32'h100, 0, 3, 32'hDEADBEEF);
        do_op(1, 0, 1, 1, 1, 5'd10, 32'h103, 0, 1, 32'h80FFFFFF);
        do_op(1, 0, 1, 0, 1, 5'd11, 32'h103, 0, 0, 32'h80FFFFFF);
        do_op(0, 1, 1, 0, 1, 5'd12, 32'h102, 32'hAB, 2, 0);
        do_op(0, 1, 0, 0, 0, 5'd0, 32'h200, 32'hCAFEF00D, 0, 0);
        do_op(1, 0, 0, 0, 1, 5'd13, 32'h101, 0, 0, 0);
        do_op(0, 1, 0, 0, 0, 5'd13, 32'h106, 1, 0, 0);
        do_op(1, 0, 0, 0, 1, 5'd14, 32'h300, 0, TO, 0);
        do_op(1, 1, 0, 0, 1, 5'd15, 32'h400, 7, 1, 32'h01234567);

        // Back-to-back ALU ops, one record per cycle.
        ex_valid = 1'b1;
        RegWrite = 1'b1;
        WriteReg = 5'd3;
        ALUResult = 32'hA;
        step();
        WriteReg = 5'd4;
        ALUResult = 32'hB;
        chk("b2b_first", wb_data, 32'hA);
        chk("b2b_first_v", wb_valid, 1);
        step();
        ex_valid = 1'b0;
        chk("b2b_second", wb_data, 32'hB);
        chk("b2b_second_reg", wb_WriteReg, 4);
        chk("b2b_second_v", wb_valid, 1);

        // Stray ack while idle has no effect.
        dmem_ack = 1'b1;
        dmem_rdata = 32'h55;
        step();
        dmem_ack = 1'b0;
        chk("stray_ack_wb", wb_valid, 0);
        chk("stray_ack_req", dmem_req, 0);
        chk("stray_ack_ready", ex_ready, 1);

        // Reset in the middle of an access.
        ex_valid = 1'b1;
        MemRead = 1'b1;
        byteOp = 1'b0;
        ALUResult = 32'h800;
        step();
        ex_valid = 1'b0;
        MemRead = 1'b0;
        chk("mid_req_up", dmem_req, 1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", dmem_req, 0);
        chk("mid_rst_ready", ex_ready, 1);
        step();
        rst_n = 1'b1;
        chk("mid_rst_no_wb", wb_valid, 0);
        step();
        chk("mid_rst_no_wb2", wb_valid, 0);
        do_op(1, 0, 0, 0, 1, 5'd20, 32'h900, 0, 2, 32'h13572468);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 6);
            a = $urandom;
            case (kind)
                0: do_op(0, 0, 0, 0, 1'($urandom), 5'($urandom), a, 0, 0, 0);
                1: do_op(1, 0, 0, 0, 1, 5'($urandom), a & ~32'h3, 0,
                         $urandom_range(0, TO), $urandom);
                2: do_op(1, 0, 1, 1'($urandom), 1, 5'($urandom), a, 0,
                         $urandom_range(0, TO), $urandom);
                3: do_op(0, 1, 0, 0, 0, 5'($urandom), a & ~32'h3, $urandom,
                         $urandom_range(0, TO), 0);
                4: do_op(0, 1, 1, 0, 0, 5'($urandom), a, $urandom,
                         $urandom_range(0, TO), 0);
                default: do_op(1'($urandom), 1, 0, 0, 1, 5'($urandom),
                               a | 32'h1, 0, 0, 0);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
